// File: rtl/load_store_aligner.sv
// load_store_aligner: data-side memory sequencer. Takes a byte-addressed
// load/store, drives one or two word beats on a 32-bit word-addressed memory,
// lane-shifts store data and byte enables, and extracts/extends load results.
module load_store_aligner #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        store,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT_LO = 2'd1,
        BEAT_HI = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Request context captured when an access is accepted
    logic        store_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic [2:0]  nbytes_q;
    logic        cross_q;
    logic [31:0] wa_q;
    logic [31:0] sdata_q;

    // Captured read words and registered results
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic [31:0] load_data_q;
    logic        done_q;
    logic        fault_q;

    // Decode of the incoming request
    logic [2:0]  req_nbytes;
    logic [3:0]  req_end;
    logic        req_cross;
    logic        req_fault;
    logic        req_accept;

    // Lane steering for the latched request
    logic [3:0]  mask;
    logic [2:0]  hi_shift;
    logic [3:0]  lo_be;
    logic [3:0]  hi_be;
    logic [31:0] lo_wdata;
    logic [31:0] hi_wdata;
    logic [31:0] raw;
    logic [31:0] ext_data;

    // Size code to byte count; the reserved code 11 behaves as a word
    always_comb begin
        case (size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
    end

    assign req_end    = {2'b00, address[1:0]} + {1'b0, req_nbytes};
    assign req_cross  = (req_end > 4'd4);
    assign req_fault  = start && req_cross && !ALLOW_MISALIGNED;
    assign req_accept = (state_q == IDLE) && start && !req_fault;

    // Byte mask of the access before shifting into lanes
    always_comb begin
        case (nbytes_q)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    // The high beat carries whatever spilled past lane 3 of the low beat
    assign hi_shift = 3'd4 - {1'b0, off_q};
    assign lo_be    = mask << off_q;
    assign hi_be    = mask >> hi_shift;
    assign lo_wdata = sdata_q << {off_q, 3'b000};
    assign hi_wdata = sdata_q >> {hi_shift, 3'b000};

    // Load extraction: realign the two captured words, then truncate and extend
    assign raw = 32'({hi_q, lo_q} >> {off_q, 3'b000});

    // Truncate to the access width and sign- or zero-extend
    always_comb begin
        case (nbytes_q)
            3'd1:    ext_data = {{24{!unsigned_q && raw[7]}}, raw[7:0]};
            3'd2:    ext_data = {{16{!unsigned_q && raw[15]}}, raw[15:0]};
            default: ext_data = raw;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory request outputs; requests are pure functions of
    // the state and latched context so they stay stable across wait cycles
    always_comb begin
        state_d     = state_q;
        mem_addr    = 32'd0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_byte_en = 4'b0000;
        mem_wdata   = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_accept) begin
                    state_d = BEAT_LO;
                end
            end
            BEAT_LO: begin
                mem_addr    = wa_q;
                mem_read    = !store_q;
                mem_write   = store_q;
                mem_byte_en = lo_be;
                mem_wdata   = store_q ? lo_wdata : 32'd0;
                if (mem_ready) begin
                    state_d = cross_q ? BEAT_HI : FINISH;
                end
            end
            BEAT_HI: begin
                mem_addr    = wa_q + 32'd4;
                mem_read    = !store_q;
                mem_write   = store_q;
                mem_byte_en = hi_be;
                mem_wdata   = store_q ? hi_wdata : 32'd0;
                if (mem_ready) begin
                    state_d = FINISH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, read-data capture and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            store_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            off_q       <= 2'b00;
            nbytes_q    <= 3'd0;
            cross_q     <= 1'b0;
            wa_q        <= 32'd0;
            sdata_q     <= 32'd0;
            lo_q        <= 32'd0;
            hi_q        <= 32'd0;
            load_data_q <= 32'd0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            done_q  <= (state_q == FINISH);
            fault_q <= (state_q == IDLE) && req_fault;
            if (req_accept) begin
                store_q    <= store;
                unsigned_q <= load_unsigned;
                off_q      <= address[1:0];
                nbytes_q   <= req_nbytes;
                cross_q    <= req_cross;
                wa_q       <= {address[31:2], 2'b00};
                sdata_q    <= store_data;
            end
            if ((state_q == BEAT_LO) && mem_ready) begin
                lo_q <= mem_rdata;
            end
            if ((state_q == BEAT_HI) && mem_ready) begin
                hi_q <= mem_rdata;
            end
            if ((state_q == FINISH) && !store_q) begin
                load_data_q <= ext_data;
            end
        end
    end

    assign load_data = load_data_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_aligner.sv
// Directed bench for load_store_aligner: one instance with misaligned
// splitting enabled and one with it disabled, driven from shared inputs.
module tb_load_store_aligner;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        start_nm;
    logic        store;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [31:0] mem_addr,  n_mem_addr;
    logic        mem_read,  n_mem_read;
    logic        mem_write, n_mem_write;
    logic [3:0]  mem_byte_en, n_mem_byte_en;
    logic [31:0] mem_wdata, n_mem_wdata;
    logic [31:0] load_data, n_load_data;
    logic        busy,  n_busy;
    logic        done,  n_done;
    logic        fault, n_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    load_store_aligner #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .store(store), .size(size),
        .load_unsigned(load_unsigned), .address(address), .store_data(store_data),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .load_data(load_data), .busy(busy), .done(done),
        .fault(fault)
    );

    load_store_aligner #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clock(clock), .reset(reset), .start(start_nm), .store(store), .size(size),
        .load_unsigned(load_unsigned), .address(address), .store_data(store_data),
        .mem_addr(n_mem_addr), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .mem_byte_en(n_mem_byte_en), .mem_wdata(n_mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .load_data(n_load_data), .busy(n_busy), .done(n_done),
        .fault(n_fault)
    );

    // Present a request for one cycle; returns 1ns into the first cycle after it
    task automatic issue(input bit nm, input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] sd);
        @(posedge clock); #1;
        store = st; size = sz; load_unsigned = uns; address = addr; store_data = sd;
        if (nm) start_nm = 1'b1; else start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; start_nm = 1'b0;
        $display("issue nm=%0d store=%0d size=%0d uns=%0d addr=%h data=%h", nm, st, sz, uns, addr, sd);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({mem_read, mem_write, mem_byte_en, busy, done, fault} !== 9'd0) begin
            n_bad++; $display("FAIL reset_ctl: got %b expected 0", {mem_read, mem_write, mem_byte_en, busy, done, fault});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, load_data} !== 96'd0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, load_data});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_lw;
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        @(negedge clock); // cycle 1
        n_cmp++;
        if ({mem_read, mem_write, mem_byte_en, mem_addr} !== {2'b10, 4'b1111, 32'h100}) begin
            n_bad++; $display("FAIL lw_beat: got %b/%b %b %h expected 1/0 1111 00000100", mem_read, mem_write, mem_byte_en, mem_addr);
        end
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_bad++; $display("FAIL lw_busy1: got %b expected 10", {busy, done});
        end
        @(negedge clock); // cycle 2
        n_cmp++;
        if ({mem_read, done, busy} !== 3'b001) begin
            n_bad++; $display("FAIL lw_finish: got %b expected 001", {mem_read, done, busy});
        end
        @(negedge clock); // cycle 3
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_bad++; $display("FAIL lw_done: got %b expected 10", {done, busy});
        end
        n_cmp++;
        if (load_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL lw_data: got %h expected deadbeef", load_data);
        end
        @(negedge clock); // cycle 4
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL lw_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_lb_lh;
        mem_ready = 1'b1; mem_rdata = 32'h80123456;
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        @(negedge clock);
        n_cmp++;
        if ({mem_byte_en, mem_addr} !== {4'b1000, 32'h100}) begin
            n_bad++; $display("FAIL lb_beat: got %b %h expected 1000 00000100", mem_byte_en, mem_addr);
        end
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({done, load_data} !== {1'b1, 32'hFFFFFF80}) begin
            n_bad++; $display("FAIL lb_signed: got %b %h expected 1 ffffff80", done, load_data);
        end
        issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({done, load_data} !== {1'b1, 32'h00000080}) begin
            n_bad++; $display("FAIL lbu: got %b %h expected 1 00000080", done, load_data);
        end
        mem_rdata = 32'h80011234;
        issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        @(negedge clock);
        n_cmp++;
        if (mem_byte_en !== 4'b1100) begin
            n_bad++; $display("FAIL lh_be: got %b expected 1100", mem_byte_en);
        end
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({done, load_data} !== {1'b1, 32'hFFFF8001}) begin
            n_bad++; $display("FAIL lh_signed: got %b %h expected 1 ffff8001", done, load_data);
        end
    endtask

    task automatic test_sw_cross;
        mem_ready = 1'b1;
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344);
        @(negedge clock); // BEAT_LO
        n_cmp++;
        if ({mem_write, mem_read, mem_addr, mem_byte_en, mem_wdata} !== {2'b10, 32'h100, 4'b1100, 32'h33440000}) begin
            n_bad++; $display("FAIL sw_lo: got w%b r%b %h %b %h expected w1 r0 00000100 1100 33440000", mem_write, mem_read, mem_addr, mem_byte_en, mem_wdata);
        end
        @(negedge clock); // BEAT_HI
        n_cmp++;
        if ({mem_write, mem_addr, mem_byte_en, mem_wdata} !== {1'b1, 32'h104, 4'b0011, 32'h00001122}) begin
            n_bad++; $display("FAIL sw_hi: got w%b %h %b %h expected w1 00000104 0011 00001122", mem_write, mem_addr, mem_byte_en, mem_wdata);
        end
        @(negedge clock); // FINISH
        n_cmp++;
        if ({mem_write, done} !== 2'b00) begin
            n_bad++; $display("FAIL sw_finish: got %b expected 00", {mem_write, done});
        end
        @(negedge clock);
        n_cmp++;
        if ({done, load_data} !== {1'b1, 32'hFFFF8001}) begin
            n_bad++; $display("FAIL sw_done: got %b %h expected 1 ffff8001", done, load_data);
        end
    endtask

    task automatic test_lh_wrap;
        mem_ready = 1'b1; mem_rdata = 32'hAA000000;
        issue(1'b0, 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
        @(negedge clock);
        n_cmp++;
        if ({mem_read, mem_addr, mem_byte_en} !== {1'b1, 32'hFFFFFFFC, 4'b1000}) begin
            n_bad++; $display("FAIL wrap_lo: got %b %h %b expected 1 fffffffc 1000", mem_read, mem_addr, mem_byte_en);
        end
        @(posedge clock); #1;
        mem_rdata = 32'h00000055;
        @(negedge clock);
        n_cmp++;
        if ({mem_read, mem_addr, mem_byte_en} !== {1'b1, 32'h0, 4'b0001}) begin
            n_bad++; $display("FAIL wrap_hi: got %b %h %b expected 1 00000000 0001", mem_read, mem_addr, mem_byte_en);
        end
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if ({done, load_data} !== {1'b1, 32'h000055AA}) begin
            n_bad++; $display("FAIL wrap_data: got %b %h expected 1 000055aa", done, load_data);
        end
    endtask

    task automatic test_wait_states;
        mem_ready = 1'b0; mem_rdata = 32'h12345678;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({mem_read, mem_addr, mem_byte_en, done} !== {1'b1, 32'h200, 4'b1111, 1'b0}) begin
                n_bad++; $display("FAIL wait_hold%0d: got %b %h %b %b expected 1 00000200 1111 0", c, mem_read, mem_addr, mem_byte_en, done);
            end
            @(posedge clock); #1;
            if (c == 1) begin
                start = 1'b1; address = 32'h300; // must be ignored while busy
            end else if (c == 2) begin
                start = 1'b0;
            end else begin
                mem_ready = 1'b1;
            end
        end
        @(negedge clock); // cycle 4
        n_cmp++;
        if ({mem_read, mem_addr, done} !== {1'b1, 32'h200, 1'b0}) begin
            n_bad++; $display("FAIL wait_ready: got %b %h %b expected 1 00000200 0", mem_read, mem_addr, done);
        end
        @(posedge clock); #1;
        mem_ready = 1'b0;
        @(negedge clock); // cycle 5
        n_cmp++;
        if ({mem_read, done} !== 2'b00) begin
            n_bad++; $display("FAIL wait_finish: got %b expected 00", {mem_read, done});
        end
        @(negedge clock); // cycle 6
        n_cmp++;
        if ({done, load_data} !== {1'b1, 32'h12345678}) begin
            n_bad++; $display("FAIL wait_done: got %b %h expected 1 12345678", done, load_data);
        end
        @(negedge clock); // cycle 7: ignored start left nothing behind
        n_cmp++;
        if ({busy, mem_read} !== 2'b00) begin
            n_bad++; $display("FAIL busy_start_ignored: got %b expected 00", {busy, mem_read});
        end
    endtask

    task automatic test_reset_mid;
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h106, 32'h0);
        @(posedge clock); #1; // now in BEAT_HI
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h108}) begin
            n_bad++; $display("FAIL rmid_hi: got %b %h expected 1 00000108", mem_read, mem_addr);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({mem_read, mem_write, mem_byte_en, busy, done, fault} !== 9'd0) begin
            n_bad++; $display("FAIL rmid_ctl: got %b expected 0", {mem_read, mem_write, mem_byte_en, busy, done, fault});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, load_data} !== 96'd0) begin
            n_bad++; $display("FAIL rmid_data: got %h expected 0", {mem_addr, mem_wdata, load_data});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({done, busy} !== 2'b00) begin
                n_bad++; $display("FAIL rmid_nodone%0d: got %b expected 00", c, {done, busy});
            end
        end
    endtask

    task automatic test_fault;
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h1, 32'h0);
        @(negedge clock);
        n_cmp++;
        if ({n_fault, n_busy, n_mem_read, n_mem_write, fault} !== 5'b10000) begin
            n_bad++; $display("FAIL fault_pulse: got %b expected 10000", {n_fault, n_busy, n_mem_read, n_mem_write, fault});
        end
        @(negedge clock);
        n_cmp++;
        if ({n_fault, n_busy, n_mem_read, n_done} !== 4'b0000) begin
            n_bad++; $display("FAIL fault_after: got %b expected 0000", {n_fault, n_busy, n_mem_read, n_done});
        end
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h1, 32'h0);
        @(negedge clock);
        n_cmp++;
        if ({n_fault, n_busy, n_mem_byte_en} !== {2'b01, 4'b0110}) begin
            n_bad++; $display("FAIL nm_lh_nocross: got %b %b expected 01 0110", {n_fault, n_busy}, n_mem_byte_en);
        end
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({n_done, n_load_data} !== {1'b1, 32'hFFFFADF0}) begin
            n_bad++; $display("FAIL nm_lh_data: got %b %h expected 1 ffffadf0", n_done, n_load_data);
        end
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        @(negedge clock);
        n_cmp++;
        if ({n_mem_read, n_mem_addr} !== {1'b1, 32'h4}) begin
            n_bad++; $display("FAIL nm_lw_beat: got %b %h expected 1 00000004", n_mem_read, n_mem_addr);
        end
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({n_done, n_load_data} !== {1'b1, 32'h0BADF00D}) begin
            n_bad++; $display("FAIL nm_lw_data: got %b %h expected 1 0badf00d", n_done, n_load_data);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_nm = 1'b0; store = 1'b0; size = 2'b00;
        load_unsigned = 1'b0; address = 32'h0; store_data = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        test_reset;
        test_lw;
        test_lb_lh;
        test_sw_cross;
        test_lh_wrap;
        test_wait_states;
        test_reset_mid;
        test_fault;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
